reg_share_arbiter: RTL and testbench

Round-robin arbiter sharing one W-bit storage register among N requesters. Each winning requester gets a grant, its data word is captured into the shared register, and it keeps ownership for a guaranteed minimum tenure. Ownership is then released to the next requester in rotation. The block sits in front of the shared flip-flop bank and is the only writer of it.

---
 rtl/reg_share_pkg.sv | 31 +++
 rtl/reg_share_arbiter_rr_pick.sv | 31 +++
 rtl/reg_share_arbiter.sv | 114 +++++++++++
 tb/tb_reg_share_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_share_pkg.sv
// Shared types and width helpers for the shared-register arbiter.
// State encoding and clog2-derived index/counter widths.
package reg_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam int unsigned N_DEF    = 4;
  localparam int unsigned W_DEF    = 8;
  localparam int unsigned HOLD_DEF = 2;

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(
    input int unsigned h
  );
    return (h > 0) ? $clog2(h + 1) : 1;
  endfunction

  localparam int unsigned OWNER_W = idx_w(N_DEF);
  localparam int unsigned PTR_W   = idx_w(N_DEF);
  localparam int unsigned CNT_W   = cnt_w(HOLD_DEF);

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 found
);
  import reg_share_pkg::*;

  localparam int IW = idx_w(N);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of one shared W-bit register with a
// guaranteed minimum tenure per grant.
module reg_share_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic [W-1:0]         q,
  output logic                 q_valid,
  output logic                 busy
);
  import reg_share_pkg::*;

  localparam int IW = idx_w(N);
  localparam int CW = cnt_w(HOLD);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic          qv_q, qv_d;

  logic [IW-1:0] win;
  logic          found;
  logic [N-1:0]  others;
  logic          rel;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .winner(win),
    .found (found)
  );

  // Anyone else waiting forces the owner out once tenure is met.
  assign others = req & ~grant_q;
  assign rel    = !req[owner_q] || (others != '0);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    qv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = N'(1) << win;
          owner_d = win;
          state_d = LOAD;
        end
      end
      LOAD: begin
        q_d     = data[owner_q*W +: W];
        qv_d    = 1'b1;
        cnt_d   = CW'(HOLD - 1);
        state_d = reg_share_pkg::HOLD;
      end
      reg_share_pkg::HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rel) begin
          grant_d = '0;
          ptr_d   = (owner_q == IW'(N - 1)) ?
                    '0 : owner_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign q       = q_q;
  assign q_valid = qv_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: directed scenarios plus a
// randomized run against a tenure-age reference model.
module tb_reg_share_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] data  = '0;
  logic [N-1:0]   grant;
  logic [1:0]     owner;
  logic [W-1:0]   q;
  logic           q_valid;
  logic           busy;

  int tests = 0;
  int fails = 0;

  bit       m_on;
  int       m_owner;
  int       m_age;
  int       m_ptr;
  bit [7:0] m_q;
  bit       m_qv;

  reg_share_arbiter #(
    .N(N), .W(W), .HOLD(HOLD)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .data   (data),
    .grant  (grant),
    .owner  (owner),
    .q      (q),
    .q_valid(q_valid),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m_on = 0; m_owner = 0; m_age = 0;
    m_ptr = 0; m_q = 0; m_qv = 0;
  endtask

  // Tenure described by age = edges since grant was issued.
  task automatic model_step(
    input logic [N-1:0]   r,
    input logic [N*W-1:0] d
  );
    bit nqv;
    bit others;
    nqv = 0;
    if (!m_on) begin
      for (int i = N - 1; i >= 0; i--)
        if (r[(m_ptr + i) % N]) begin
          m_on = 1;
          m_owner = (m_ptr + i) % N;
          m_age = 0;
        end
    end else if (m_age == 0) begin
      m_q = d[m_owner*W +: W];
      nqv = 1;
      m_age = 1;
    end else if (m_age < HOLD) begin
      m_age++;
    end else begin
      others = 0;
      for (int i = 0; i < N; i++)
        if (i != m_owner && r[i]) others = 1;
      if (!r[m_owner] || others) begin
        m_on = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end
    m_qv = nqv;
  endtask

  task automatic do_reset();
    req = '0;
    data = '0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({grant, owner, q, q_valid, busy} !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: got %h want 0000",
               {grant, owner, q, q_valid, busy});
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    data[1*W +: W] = 8'hA5;
    tick();
    tests++;
    if ({grant, owner, busy, q_valid} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL single_grant: got g=%b o=%0d b=%b v=%b",
               grant, owner, busy, q_valid);
    end
    tick();
    tests++;
    if ({q, q_valid, grant} !== {8'hA5, 1'b1, 4'b0010}) begin
      fails++;
      $display("FAIL single_load: got q=%h v=%b g=%b want a5 1 0010",
               q, q_valid, grant);
    end
    tick();
    tests++;
    if ({q, q_valid, grant} !== {8'hA5, 1'b0, 4'b0010}) begin
      fails++;
      $display("FAIL single_hold: got q=%h v=%b g=%b want a5 0 0010",
               q, q_valid, grant);
    end
    req = '0;
    tick();
    tests++;
    if ({grant, busy, q} !== {4'b0000, 1'b0, 8'hA5}) begin
      fails++;
      $display("FAIL single_release: got g=%b b=%b q=%h", grant, busy, q);
    end
  endtask

  task automatic test_contention();
    logic [3:0] eg;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) data[i*W +: W] = 8'(8'h10 + i);
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      tick();
      tests++;
      if ({grant, owner, busy} !== {eg, 2'(k % 4), 1'b1}) begin
        fails++;
        $display("FAIL cont_grant%0d: got g=%b o=%0d want g=%b",
                 k, grant, owner, eg);
      end
      tick();
      tests++;
      if ({q, q_valid} !== {8'(8'h10 + k % 4), 1'b1}) begin
        fails++;
        $display("FAIL cont_q%0d: got q=%h v=%b want %h 1",
                 k, q, q_valid, 8'(8'h10 + k % 4));
      end
      tick();
      tick();
      tests++;
      if ({grant, busy} !== 5'b0) begin
        fails++;
        $display("FAIL cont_idle%0d: got g=%b b=%b want 0 0",
                 k, grant, busy);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1000;
    repeat (3) tick();
    tests++;
    if ({grant, owner} !== {4'b1000, 2'd3}) begin
      fails++;
      $display("FAIL wrap_owner3: got g=%b o=%0d", grant, owner);
    end
    req = 4'b1001;
    tick();
    tests++;
    if ({grant, busy} !== 5'b0) begin
      fails++;
      $display("FAIL wrap_release: got g=%b b=%b", grant, busy);
    end
    tick();
    tests++;
    if ({grant, owner} !== {4'b0001, 2'd0}) begin
      fails++;
      $display("FAIL wrap_next: got g=%b o=%0d want 0001 0",
               grant, owner);
    end
  endtask

  task automatic test_sole_hold();
    int pulses;
    int bad;
    do_reset();
    req = 4'b0100;
    data[2*W +: W] = 8'h77;
    pulses = 0;
    bad = 0;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (q_valid) pulses++;
      if (grant !== 4'b0100) bad++;
    end
    tests++;
    if (pulses != 1 || bad != 0) begin
      fails++;
      $display("FAIL sole_hold: got pulses=%0d badgrant=%0d want 1 0",
               pulses, bad);
    end
    req = 4'b0101;
    tick();
    tests++;
    if (grant !== 4'b0000) begin
      fails++;
      $display("FAIL sole_forced_release: got %b want 0000", grant);
    end
    tick();
    tests++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("FAIL sole_next: got %b want 0001", grant);
    end
  endtask

  task automatic test_data_isolation();
    do_reset();
    req = 4'b0100;
    data[2*W +: W] = 8'h3C;
    repeat (2) tick();
    data[2*W +: W] = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if ({q, q_valid, grant} !== {8'h3C, 1'b0, 4'b0100}) begin
        fails++;
        $display("FAIL data_iso%0d: got q=%h v=%b g=%b want 3c 0 0100",
                 c, q, q_valid, grant);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    data[1*W +: W] = 8'h5A;
    repeat (2) tick();
    #4;
    reset = 1'b0;
    #1;
    tests++;
    if ({grant, owner, q, q_valid, busy} !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid: got %h want 0000",
               {grant, owner, q, q_valid, busy});
    end
    req = '0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [15:0]  exp;
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 0)
        r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) r = '0;
      req = r;
      data = 32'($urandom());
      model_step(req, data);
      tick();
      exp = {m_on ? 4'(4'b0001 << m_owner) : 4'b0000,
             2'(m_owner), m_q, m_qv, m_on};
      tests++;
      if ({grant, owner, q, q_valid, busy} !== exp) begin
        fails++;
        $display("FAIL rand_c%0d: got %h want %h",
                 c, {grant, owner, q, q_valid, busy}, exp);
      end
      tests++;
      if (!$onehot0(grant)) begin
        fails++;
        $display("FAIL rand_onehot%0d: got %b want onehot0", c, grant);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_sole_hold();
    test_data_isolation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
